// File: rtl/mod_reduce_seq.sv
// Sequential modular reduction: result = a mod m by MSB-first shift/conditional-subtract.
// Define MOD_REDUCE_RADIX4_EN to retire two dividend bits per RUN cycle.
module mod_reduce_seq #(
  parameter int IN_W  = 256,
  parameter int MOD_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  a,
  input  logic [MOD_W-1:0] m,
  output logic             busy,
  output logic [MOD_W-1:0] result,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

`ifdef MOD_REDUCE_RADIX4_EN
  localparam int STEPS = 2;
  if (IN_W % 2 != 0) begin : g_odd_in_w
    $error("mod_reduce_seq: IN_W must be even when MOD_REDUCE_RADIX4_EN is defined");
  end
`else
  localparam int STEPS = 1;
`endif
  localparam int CYC   = IN_W / STEPS;
  localparam int CNT_W = $clog2(CYC + 1);

  logic [1:0]       state;
  logic [IN_W-1:0]  a_q;
  logic [MOD_W-1:0] m_q;
  logic [MOD_W:0]   r, r_nxt;
  logic [CNT_W-1:0] cnt;
  logic             zero_q;

  // One radix-2 step. r < m keeps 2r+b below 2m, so a single subtract restores r < m.
  function automatic logic [MOD_W:0] red_step(input logic [MOD_W:0] rv, input logic b,
                                              input logic [MOD_W-1:0] mv);
    logic [MOD_W+1:0] t;
    t = {rv, b};
    if (t >= {2'b00, mv}) t = t - {2'b00, mv};
    return t[MOD_W:0];
  endfunction

`ifdef MOD_REDUCE_RADIX4_EN
  logic [MOD_W:0] r_mid;
  always_comb begin
    r_mid = red_step(r, a_q[IN_W-1], m_q);
    r_nxt = red_step(r_mid, a_q[IN_W-2], m_q);
  end
`else
  always_comb r_nxt = red_step(r, a_q[IN_W-1], m_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      m_q    <= '0;
      r      <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          r   <= r_nxt;
          a_q <= a_q << STEPS;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          done   <= 1'b1;
          result <= r[MOD_W-1:0];
          err    <= zero_q;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: ;
      endcase
      // The DONE edge doubles as an accepting edge so back-to-back ops lose no cycle.
      if (start && (state == IDLE || state == DONE)) begin
        a_q    <= a;
        m_q    <= m;
        r      <= '0;
        cnt    <= CNT_W'(CYC);
        zero_q <= (m == '0);
        busy   <= 1'b1;
        state  <= (m == '0) ? DONE : RUN;
      end
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed self-checking bench for mod_reduce_seq (default parameters).
module tb_mod_reduce_seq;
  localparam int IN_W  = 256;
  localparam int MOD_W = 64;
`ifdef MOD_REDUCE_RADIX4_EN
  localparam int LAT = IN_W / 2 + 1;
`else
  localparam int LAT = IN_W + 1;
`endif
  localparam logic [MOD_W-1:0] M0 = 64'h3FFFFFF600000013;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IN_W-1:0]  a = '0;
  logic [MOD_W-1:0] m = '0;
  logic             busy, done, err;
  logic [MOD_W-1:0] result;

  int n_chk = 0;
  int n_fail = 0;

  mod_reduce_seq #(.IN_W(IN_W), .MOD_W(MOD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .m(m),
    .busy(busy), .result(result), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Drives one operation and reports latency, captured outputs and any repeat done.
  task automatic run_op(input logic [IN_W-1:0] av, input logic [MOD_W-1:0] mv,
                        output int lat, output logic [MOD_W-1:0] res, output logic e,
                        output int extra);
    @(negedge clk); a = av; m = mv; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = -1; res = '0; e = 1'b0; extra = 0;
    for (int k = 1; k <= IN_W + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; res = result; e = err; break; end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      if (done) extra = 1;
    end
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    n_chk++; if (result !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [IN_W-1:0]  av [5];
    logic [MOD_W-1:0] ex [5];
    logic [IN_W-1:0]  ones;
    logic [IN_W-1:0]  mw;
    logic [MOD_W-1:0] res;
    logic e;
    int lat, extra;
    ones = '1;
    mw = {{(IN_W-MOD_W){1'b0}}, M0};
    av[0] = 3;          ex[0] = 64'd3;
    av[1] = mw;         ex[1] = 64'd0;
    av[2] = mw + 1;     ex[2] = 64'd1;
    av[3] = 2 * mw + 5; ex[3] = 64'd5;
    av[4] = ones;       ex[4] = MOD_W'(ones % mw);
    for (int i = 0; i < 5; i++) begin
      run_op(av[i], M0, lat, res, e, extra);
      n_chk++; if (res !== ex[i]) begin n_fail++; $display("FAIL basic%0d_result got %h want %h", i, res, ex[i]); end
      n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic%0d_err got %0b want 0", i, e); end
      n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL basic%0d_latency got %0d want %0d", i, lat, LAT); end
      n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL basic%0d_single_done got extra=%0d want 0", i, extra); end
    end
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (result !== ex[4]) begin n_fail++; $display("FAIL hold_result got %h want %h", result, ex[4]); end
  endtask

  task automatic test_mzero;
    logic [MOD_W-1:0] res;
    logic e;
    int lat, extra;
    run_op(12345, 64'd0, lat, res, e, extra);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL mzero_latency got %0d want 1", lat); end
    n_chk++; if (e !== 1'b1) begin n_fail++; $display("FAIL mzero_err got %0b want 1", e); end
    n_chk++; if (res !== '0) begin n_fail++; $display("FAIL mzero_result got %h want 0", res); end
    n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL mzero_single_done got extra=%0d want 0", extra); end
    run_op(12345, 64'd7, lat, res, e, extra);
    n_chk++; if (res !== 64'd4) begin n_fail++; $display("FAIL after_mzero_result got %h want 4", res); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL after_mzero_err got %0b want 0", e); end
  endtask

  task automatic test_mid_start;
    int ndone, lat;
    logic [MOD_W-1:0] res;
    @(negedge clk); a = 12345; m = 7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; lat = -1; res = '0;
    for (int k = 1; k <= IN_W + 60; k++) begin
      if (k == 11) begin a = 99; m = 5; start = 1'b1; end
      if (k == 12) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; res = result; end
      end
    end
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL mid_start_done_count got %0d want 1", ndone); end
    n_chk++; if (res !== 64'd4) begin n_fail++; $display("FAIL mid_start_result got %h want 4", res); end
    n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL mid_start_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid;
    int ndone, lat;
    logic [MOD_W-1:0] res;
    @(negedge clk); a = 12345; m = 7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (100) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %0b want 0", done); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err got %0b want 0", err); end
    n_chk++; if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result got %h want 0", result); end
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; if (done) ndone++; end
    n_chk++; if (ndone !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", ndone); end
    @(negedge clk); rst_n = 1'b1; a = 12345; m = 10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_release_accept got busy=%0b want 1", busy); end
    lat = -1; res = '0;
    for (int k = 1; k <= IN_W + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; res = result; break; end
    end
    n_chk++; if (res !== 64'd5) begin n_fail++; $display("FAIL rst_release_result got %h want 5", res); end
    n_chk++; if (lat !== LAT) begin n_fail++; $display("FAIL rst_release_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2;
    logic [MOD_W-1:0] res1, res2;
    logic busy_at_done;
    @(negedge clk); a = 3; m = 7; start = 1'b1;
    @(posedge clk); #1; a = 12345;
    lat1 = -1; res1 = '0; busy_at_done = 1'b0;
    for (int k = 1; k <= IN_W + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = k; res1 = result; busy_at_done = busy; break; end
    end
    start = 1'b0;
    lat2 = -1; res2 = '0;
    for (int k = 1; k <= IN_W + 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = k; res2 = result; break; end
    end
    n_chk++; if (res1 !== 64'd3) begin n_fail++; $display("FAIL b2b_result1 got %h want 3", res1); end
    n_chk++; if (lat1 !== LAT) begin n_fail++; $display("FAIL b2b_latency1 got %0d want %0d", lat1, LAT); end
    n_chk++; if (busy_at_done !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got %0b want 1", busy_at_done); end
    n_chk++; if (res2 !== 64'd4) begin n_fail++; $display("FAIL b2b_result2 got %h want 4", res2); end
    n_chk++; if (lat2 !== LAT) begin n_fail++; $display("FAIL b2b_spacing got %0d want %0d", lat2, LAT); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mzero;
    test_mid_start;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
